// File: rtl/axi4_pkg.sv
// Shared types for the two-master AXI4 read arbiter: FSM state, AR payload
// bundle, channel widths and the clock-annotation parameter type.
package axi4_pkg;

    typedef logic [31:0] std_clock_info_t;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_USER_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } axi4_read_arb_state_t;

    // Field order matches the flattened concatenation used by the arbiter
    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [1:0]            burst;
        logic [3:0]            cache;
        logic [7:0]            len;
        logic                  lock;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [2:0]            size;
        logic [AXI_USER_W-1:0] user;
        logic [AXI_ID_W-1:0]   id;
    } axi4_ar_payload_t;

endpackage

// File: rtl/axi4_grant_select.sv
// Two-requester grant selection. Output 0 selects master 0, 1 selects master 1.
// AXI4_READ_ARBITER_RR_EN defined: simultaneous requests go to the master that
// was not served last. Undefined: master 0 always wins a tie.
module axi4_grant_select (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant
);

`ifdef AXI4_READ_ARBITER_RR_EN
    // Round-robin: on a tie, hand the slave to whoever did not have it last
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = req1;
        end
    end
`else
    // History is irrelevant with fixed priority
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Fixed priority: master 1 only wins when master 0 is not asking
    always_comb begin
        grant = req1 && !req0;
    end
`endif

endmodule

// File: rtl/axi4_read_arbiter.sv
// Shares one AXI4 read slave between two masters with a single burst in
// flight. Grant is registered in IDLE; AR and R channels are then steered
// combinationally by that registered grant only (the R id is never used).
// Optional round-robin arbitration: define AXI4_READ_ARBITER_RR_EN.
module axi4_read_arbiter
    import axi4_pkg::*;
#(
    parameter std_clock_info_t CLOCK_INFO = 'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    // read-address channel, master 0
    input  logic                  axi_ar_in0_valid,
    output logic                  axi_ar_in0_ready,
    input  logic [AXI_ADDR_W-1:0] axi_ar_in0_addr,
    input  logic [1:0]            axi_ar_in0_burst,
    input  logic [3:0]            axi_ar_in0_cache,
    input  logic [7:0]            axi_ar_in0_len,
    input  logic                  axi_ar_in0_lock,
    input  logic [2:0]            axi_ar_in0_prot,
    input  logic [3:0]            axi_ar_in0_qos,
    input  logic [2:0]            axi_ar_in0_size,
    input  logic [AXI_USER_W-1:0] axi_ar_in0_user,
    input  logic [AXI_ID_W-1:0]   axi_ar_in0_id,
    // read-address channel, master 1
    input  logic                  axi_ar_in1_valid,
    output logic                  axi_ar_in1_ready,
    input  logic [AXI_ADDR_W-1:0] axi_ar_in1_addr,
    input  logic [1:0]            axi_ar_in1_burst,
    input  logic [3:0]            axi_ar_in1_cache,
    input  logic [7:0]            axi_ar_in1_len,
    input  logic                  axi_ar_in1_lock,
    input  logic [2:0]            axi_ar_in1_prot,
    input  logic [3:0]            axi_ar_in1_qos,
    input  logic [2:0]            axi_ar_in1_size,
    input  logic [AXI_USER_W-1:0] axi_ar_in1_user,
    input  logic [AXI_ID_W-1:0]   axi_ar_in1_id,
    // read-data channel back to master 0
    output logic                  axi_r_out0_valid,
    input  logic                  axi_r_out0_ready,
    output logic [AXI_DATA_W-1:0] axi_r_out0_data,
    output logic                  axi_r_out0_last,
    output logic [1:0]            axi_r_out0_resp,
    output logic [AXI_ID_W-1:0]   axi_r_out0_id,
    // read-data channel back to master 1
    output logic                  axi_r_out1_valid,
    input  logic                  axi_r_out1_ready,
    output logic [AXI_DATA_W-1:0] axi_r_out1_data,
    output logic                  axi_r_out1_last,
    output logic [1:0]            axi_r_out1_resp,
    output logic [AXI_ID_W-1:0]   axi_r_out1_id,
    // shared read-address channel to slave
    output logic                  axi_ar_out_valid,
    input  logic                  axi_ar_out_ready,
    output logic [AXI_ADDR_W-1:0] axi_ar_out_addr,
    output logic [1:0]            axi_ar_out_burst,
    output logic [3:0]            axi_ar_out_cache,
    output logic [7:0]            axi_ar_out_len,
    output logic                  axi_ar_out_lock,
    output logic [2:0]            axi_ar_out_prot,
    output logic [3:0]            axi_ar_out_qos,
    output logic [2:0]            axi_ar_out_size,
    output logic [AXI_USER_W-1:0] axi_ar_out_user,
    output logic [AXI_ID_W-1:0]   axi_ar_out_id,
    // shared read-data channel from slave
    input  logic                  axi_r_in_valid,
    output logic                  axi_r_in_ready,
    input  logic [AXI_DATA_W-1:0] axi_r_in_data,
    input  logic                  axi_r_in_last,
    input  logic [1:0]            axi_r_in_resp,
    input  logic [AXI_ID_W-1:0]   axi_r_in_id,
    output logic                  busy
);

    // Clock description is carried for timing annotation only
    logic [$bits(std_clock_info_t)-1:0] unused_clock_info;
    assign unused_clock_info = CLOCK_INFO;

    // STATIC_ASSERT: AR and R ports must agree on their shared field widths
    if ($bits(axi_ar_in0_addr) != $bits(axi_ar_out_addr) ||
        $bits(axi_ar_in1_addr) != $bits(axi_ar_out_addr) ||
        $bits(axi_ar_in0_id)   != $bits(axi_ar_out_id)   ||
        $bits(axi_ar_in1_id)   != $bits(axi_ar_out_id)   ||
        $bits(axi_ar_in0_user) != $bits(axi_ar_out_user) ||
        $bits(axi_ar_in1_user) != $bits(axi_ar_out_user)) begin : static_assert_ar_widths
        $error("axi4_read_arbiter: AR port widths differ");
    end
    if ($bits(axi_r_out0_data) != $bits(axi_r_in_data) ||
        $bits(axi_r_out1_data) != $bits(axi_r_in_data) ||
        $bits(axi_r_out0_id)   != $bits(axi_r_in_id)   ||
        $bits(axi_r_out1_id)   != $bits(axi_r_in_id)) begin : static_assert_r_widths
        $error("axi4_read_arbiter: R port widths differ");
    end

    axi4_read_arb_state_t state_reg;
    logic                 grant_reg;
    logic                 last_grant_reg;
    logic                 busy_reg;
    logic                 sel_grant;

    logic             in_addr;
    logic             in_data;
    logic [1:0]       ar_valid_vec;
    logic [1:0]       ar_ready_vec;
    logic [1:0]       r_ready_vec;
    logic [1:0]       r_valid_vec;
    axi4_ar_payload_t ar_pl [2];
    axi4_ar_payload_t ar_sel;
    logic             ar_hs;
    logic             r_last_hs;

    assign ar_valid_vec = {axi_ar_in1_valid, axi_ar_in0_valid};
    assign r_ready_vec  = {axi_r_out1_ready, axi_r_out0_ready};

    assign ar_pl[0] = {axi_ar_in0_addr, axi_ar_in0_burst, axi_ar_in0_cache, axi_ar_in0_len,
                       axi_ar_in0_lock, axi_ar_in0_prot, axi_ar_in0_qos, axi_ar_in0_size,
                       axi_ar_in0_user, axi_ar_in0_id};
    assign ar_pl[1] = {axi_ar_in1_addr, axi_ar_in1_burst, axi_ar_in1_cache, axi_ar_in1_len,
                       axi_ar_in1_lock, axi_ar_in1_prot, axi_ar_in1_qos, axi_ar_in1_size,
                       axi_ar_in1_user, axi_ar_in1_id};

    // Reset also silences every handshake signal within the reset cycle itself
    assign in_addr = (state_reg == ADDR) && !rst;
    assign in_data = (state_reg == DATA) && !rst;

    axi4_grant_select u_grant_select (
        .req0       (axi_ar_in0_valid),
        .req1       (axi_ar_in1_valid),
        .last_grant (last_grant_reg),
        .grant      (sel_grant)
    );

    // Per-master steering: only the registered owner sees ready / valid
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign ar_ready_vec[gi] = in_addr && (grant_reg == (gi == 1)) && axi_ar_out_ready;
        assign r_valid_vec[gi]  = in_data && (grant_reg == (gi == 1)) && axi_r_in_valid;
    end

    assign axi_ar_in0_ready = ar_ready_vec[0];
    assign axi_ar_in1_ready = ar_ready_vec[1];
    assign axi_r_out0_valid = r_valid_vec[0];
    assign axi_r_out1_valid = r_valid_vec[1];

    // AR channel mirrors the owner; a dropped valid is passed through as-is
    assign ar_sel           = ar_pl[grant_reg];
    assign axi_ar_out_valid = in_addr && ar_valid_vec[grant_reg];
    assign axi_ar_out_addr  = ar_sel.addr;
    assign axi_ar_out_burst = ar_sel.burst;
    assign axi_ar_out_cache = ar_sel.cache;
    assign axi_ar_out_len   = ar_sel.len;
    assign axi_ar_out_lock  = ar_sel.lock;
    assign axi_ar_out_prot  = ar_sel.prot;
    assign axi_ar_out_qos   = ar_sel.qos;
    assign axi_ar_out_size  = ar_sel.size;
    assign axi_ar_out_user  = ar_sel.user;
    assign axi_ar_out_id    = ar_sel.id;

    // R payload fans out to both masters; valid is the qualifier
    assign axi_r_in_ready  = in_data && r_ready_vec[grant_reg];
    assign axi_r_out0_data = axi_r_in_data;
    assign axi_r_out0_last = axi_r_in_last;
    assign axi_r_out0_resp = axi_r_in_resp;
    assign axi_r_out0_id   = axi_r_in_id;
    assign axi_r_out1_data = axi_r_in_data;
    assign axi_r_out1_last = axi_r_in_last;
    assign axi_r_out1_resp = axi_r_in_resp;
    assign axi_r_out1_id   = axi_r_in_id;

    assign ar_hs     = axi_ar_out_valid && axi_ar_out_ready;
    assign r_last_hs = axi_r_in_valid && axi_r_in_ready && axi_r_in_last;
    assign busy      = busy_reg;

    // Burst sequencer: arbitrate in IDLE, forward AR in ADDR, drain R in DATA
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|ar_valid_vec) begin
                        grant_reg <= sel_grant;
                        state_reg <= ADDR;
                        busy_reg  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (r_last_hs) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
`ifdef AXI4_READ_ARBITER_RR_EN
                        last_grant_reg <= grant_reg;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Randomized bench for axi4_read_arbiter. The reference model works at burst
// level: per-master request counts, a tie-break rule with a last-served
// memory, and sent/received beat queues. Define AXI4_READ_ARBITER_RR_EN to
// check the round-robin build.
module tb_axi4_read_arbiter;
    import axi4_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic             m_valid [2];
    axi4_ar_payload_t m_pl [2];
    logic             ar_rdy [2];
    logic             ro_valid [2];
    logic             m_rready [2];
    logic [AXI_DATA_W-1:0] ro_data [2];
    logic             ro_last [2];
    logic [1:0]       ro_resp [2];
    logic [AXI_ID_W-1:0] ro_id [2];

    logic                  ao_valid, s_ar_ready;
    logic [AXI_ADDR_W-1:0] ao_addr;
    logic [1:0]            ao_burst;
    logic [3:0]            ao_cache;
    logic [7:0]            ao_len;
    logic                  ao_lock;
    logic [2:0]            ao_prot;
    logic [3:0]            ao_qos;
    logic [2:0]            ao_size;
    logic [AXI_USER_W-1:0] ao_user;
    logic [AXI_ID_W-1:0]   ao_id;
    axi4_ar_payload_t      ao_pl;

    logic                  s_r_valid, r_in_ready, s_r_last;
    logic [AXI_DATA_W-1:0] s_r_data;
    logic [1:0]            s_r_resp;
    logic [AXI_ID_W-1:0]   s_r_id;
    logic                  busy;

    assign ao_pl = {ao_addr, ao_burst, ao_cache, ao_len, ao_lock, ao_prot, ao_qos, ao_size, ao_user, ao_id};

    always #5 clk = ~clk;

    axi4_read_arbiter dut (
        .clk(clk), .rst(rst),
        .axi_ar_in0_valid(m_valid[0]), .axi_ar_in0_ready(ar_rdy[0]),
        .axi_ar_in0_addr(m_pl[0].addr), .axi_ar_in0_burst(m_pl[0].burst), .axi_ar_in0_cache(m_pl[0].cache),
        .axi_ar_in0_len(m_pl[0].len), .axi_ar_in0_lock(m_pl[0].lock), .axi_ar_in0_prot(m_pl[0].prot),
        .axi_ar_in0_qos(m_pl[0].qos), .axi_ar_in0_size(m_pl[0].size), .axi_ar_in0_user(m_pl[0].user),
        .axi_ar_in0_id(m_pl[0].id),
        .axi_ar_in1_valid(m_valid[1]), .axi_ar_in1_ready(ar_rdy[1]),
        .axi_ar_in1_addr(m_pl[1].addr), .axi_ar_in1_burst(m_pl[1].burst), .axi_ar_in1_cache(m_pl[1].cache),
        .axi_ar_in1_len(m_pl[1].len), .axi_ar_in1_lock(m_pl[1].lock), .axi_ar_in1_prot(m_pl[1].prot),
        .axi_ar_in1_qos(m_pl[1].qos), .axi_ar_in1_size(m_pl[1].size), .axi_ar_in1_user(m_pl[1].user),
        .axi_ar_in1_id(m_pl[1].id),
        .axi_r_out0_valid(ro_valid[0]), .axi_r_out0_ready(m_rready[0]), .axi_r_out0_data(ro_data[0]),
        .axi_r_out0_last(ro_last[0]), .axi_r_out0_resp(ro_resp[0]), .axi_r_out0_id(ro_id[0]),
        .axi_r_out1_valid(ro_valid[1]), .axi_r_out1_ready(m_rready[1]), .axi_r_out1_data(ro_data[1]),
        .axi_r_out1_last(ro_last[1]), .axi_r_out1_resp(ro_resp[1]), .axi_r_out1_id(ro_id[1]),
        .axi_ar_out_valid(ao_valid), .axi_ar_out_ready(s_ar_ready),
        .axi_ar_out_addr(ao_addr), .axi_ar_out_burst(ao_burst), .axi_ar_out_cache(ao_cache),
        .axi_ar_out_len(ao_len), .axi_ar_out_lock(ao_lock), .axi_ar_out_prot(ao_prot),
        .axi_ar_out_qos(ao_qos), .axi_ar_out_size(ao_size), .axi_ar_out_user(ao_user),
        .axi_ar_out_id(ao_id),
        .axi_r_in_valid(s_r_valid), .axi_r_in_ready(r_in_ready), .axi_r_in_data(s_r_data),
        .axi_r_in_last(s_r_last), .axi_r_in_resp(s_r_resp), .axi_r_in_id(s_r_id),
        .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    bit model_last;   // master served most recently (1 after reset)
    bit halted = 1'b0;
    int cnt [2];      // bursts each master still has to issue this round
    logic [AXI_DATA_W-1:0] tx_q [$];
    logic [AXI_DATA_W-1:0] rx_q [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_request(input int m, input int len_f, input logic [31:0] addr_f);
        m_pl[m].addr  = (addr_f != 0) ? addr_f : $urandom;
        m_pl[m].burst = 2'($urandom_range(0, 2));
        m_pl[m].cache = 4'($urandom);
        m_pl[m].len   = (len_f >= 0) ? 8'(len_f) : 8'($urandom_range(0, 7));
        m_pl[m].lock  = 1'($urandom);
        m_pl[m].prot  = 3'($urandom);
        m_pl[m].qos   = 4'($urandom);
        m_pl[m].size  = 3'($urandom);
        m_pl[m].user  = AXI_USER_W'($urandom);
        m_pl[m].id    = AXI_ID_W'($urandom);
        m_valid[m]    = 1'b1;
    endtask

    // Who should win the next arbitration, from the pending set alone
    function automatic int pick_master();
        if (cnt[0] > 0 && cnt[1] > 0) begin
`ifdef AXI4_READ_ARBITER_RR_EN
            return model_last ? 0 : 1;
`else
            return 0;
`endif
        end
        return (cnt[0] > 0) ? 0 : 1;
    endfunction

    task automatic drive_stray(input bit force_valid);
        s_r_valid = force_valid ? 1'b1 : 1'($urandom);
        s_r_data  = $urandom;
        s_r_last  = 1'($urandom);
        s_r_resp  = 2'($urandom);
        s_r_id    = AXI_ID_W'($urandom);
        m_rready[0] = 1'($urandom);
        m_rready[1] = 1'($urandom);
    endtask

    // One cycle in which the arbiter must be idle and completely quiet
    task automatic idle_cycle(input bit force_stray);
        drive_stray(force_stray);
        s_ar_ready = 1'($urandom);
        @(negedge clk);
        check_eq("idle_quiet", {busy, ao_valid, ar_rdy[0], ar_rdy[1], r_in_ready, ro_valid[0], ro_valid[1]}, 7'b0);
        @(posedge clk); #1;
    endtask

    task automatic serve_burst(input int m, input int ar_stall, input bit toggle, input int abort_after, input int len_f);
        int o;
        int stall;
        int beat;
        bit hs, have, done;
        axi4_ar_payload_t req;
        logic [AXI_DATA_W-1:0] cd;
        logic [1:0] cr;
        logic [AXI_ID_W-1:0] ci;
        o = 1 - m;
        req = m_pl[m];
        stall = (ar_stall >= 0) ? ar_stall : int'($urandom_range(0, 3));
        hs = 1'b0;
        cd = '0; cr = '0; ci = '0;
        for (int c = 0; c < 40 && !hs; c++) begin
            s_ar_ready = (stall == 0);
            if (stall > 0) stall--;
            drive_stray(1'b0);
            @(negedge clk);
            check_eq("ar_valid", ao_valid, 1'b1);
            check_eq("ar_payload", ao_pl, req);
            check_eq("ar_ready_route", {ar_rdy[m], ar_rdy[o]}, {s_ar_ready, 1'b0});
            check_eq("addr_phase_quiet", {r_in_ready, ro_valid[0], ro_valid[1], busy}, 4'b0001);
            hs = ao_valid && s_ar_ready;
            @(posedge clk); #1;
        end
        if (!hs) begin
            check_eq("ar_timeout", 1'b0, 1'b1);
            halted = 1'b1;
            return;
        end
        m_valid[m] = 1'b0;
        s_ar_ready = 1'b0;
        cnt[m]--;
        if (cnt[m] > 0) new_request(m, len_f, 32'h0);

        beat = 0; have = 1'b0; done = 1'b0;
        tx_q.delete(); rx_q.delete();
        s_r_valid = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (abort_after >= 0 && beat == abort_after) break;
            if (!have) begin
                cd = $urandom; cr = 2'($urandom); ci = AXI_ID_W'($urandom);
                have = 1'b1;
                s_r_valid = ($urandom_range(0, 3) != 0);
            end else if (!s_r_valid) begin
                s_r_valid = ($urandom_range(0, 3) != 0);
            end
            s_r_data = cd; s_r_resp = cr; s_r_id = ci;
            s_r_last = (beat == int'(req.len));
            if (toggle) m_rready[m] = !m_rready[m];
            else        m_rready[m] = 1'($urandom);
            m_rready[o] = 1'($urandom);
            @(negedge clk);
            check_eq("r_valid_route", {ro_valid[m], ro_valid[o]}, {s_r_valid, 1'b0});
            check_eq("r_ready_route", r_in_ready, m_rready[m]);
            check_eq("data_phase_quiet", {ao_valid, ar_rdy[0], ar_rdy[1], busy}, 4'b0001);
            if (s_r_valid)
                check_eq("r_payload", {ro_data[m], ro_last[m], ro_resp[m], ro_id[m]}, {cd, s_r_last, cr, ci});
            if (ro_valid[m] && m_rready[m]) rx_q.push_back(ro_data[m]);
            if (s_r_valid && r_in_ready) begin
                tx_q.push_back(cd);
                have = 1'b0;
                if (s_r_last) done = 1'b1;
                beat++;
            end
            @(posedge clk); #1;
        end
        if (abort_after >= 0) return;
        s_r_valid = 1'b0;
        if (!done) begin
            check_eq("r_timeout", 1'b0, 1'b1);
            halted = 1'b1;
            return;
        end
        check_eq("beats_sent", tx_q.size(), int'(req.len) + 1);
        check_eq("beats_rcvd", rx_q.size(), tx_q.size());
        for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++)
            check_eq("beat_order", rx_q[i], tx_q[i]);
        model_last = (m == 1);
        $display("burst m%0d addr=%08h len=%0d beats=%0d", m, req.addr, req.len, rx_q.size());
    endtask

    // Issue c0/c1 bursts per master; each master re-requests as soon as its AR is taken
    task automatic run_round(input int c0, input int c1, input int stall, input bit toggle,
                             input int len_f, input logic [31:0] a0, input logic [31:0] a1);
        int m;
        if (halted) return;
        cnt[0] = c0; cnt[1] = c1;
        if (c0 > 0) new_request(0, len_f, a0);
        if (c1 > 0) new_request(1, len_f, a1);
        while (!halted) begin
            idle_cycle(1'b0);
            if (cnt[0] == 0 && cnt[1] == 0) break;
            m = pick_master();
            serve_burst(m, stall, toggle, -1, len_f);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        m_pl[0] = '0; m_pl[1] = '0;
        m_rready[0] = 1'b1; m_rready[1] = 1'b1;
        s_ar_ready = 1'b1;
        s_r_valid = 1'b1; s_r_data = 32'hdead_beef; s_r_last = 1'b1; s_r_resp = 2'b0; s_r_id = '0;
        cnt[0] = 0; cnt[1] = 0;
        model_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("reset_state", {busy, ao_valid, ar_rdy[0], ar_rdy[1], r_in_ready, ro_valid[0], ro_valid[1]}, 7'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous requests straight after reset
        run_round(1, 1, -1, 1'b0, -1, 32'h100, 32'h200);
        // Both masters keep requesting
        run_round(3, 3, -1, 1'b0, -1, 32'h0, 32'h0);
        // Single request, len 3
        run_round(1, 0, 0, 1'b0, 3, 32'h1000, 32'h0);
        // Backpressure: AR stalled 5 cycles, master ready toggling, len 7
        run_round(0, 1, 5, 1'b1, 7, 32'h0, 32'h2000);
        // Stray slave responses while idle
        repeat (4) idle_cycle(1'b1);

        // Reset after two beats of a len 3 burst
        if (!halted) begin
            cnt[0] = 1; cnt[1] = 0;
            new_request(0, 3, 32'h3000);
            idle_cycle(1'b0);
            serve_burst(0, 0, 1'b0, 2, 3);
            rst = 1'b1;
            s_r_valid = 1'b1; s_r_last = 1'b0;
            m_rready[0] = 1'b1; m_rready[1] = 1'b1;
            s_ar_ready = 1'b1;
            @(negedge clk);
            check_eq("rst_same_cycle", {ao_valid, ar_rdy[0], ar_rdy[1], r_in_ready, ro_valid[0], ro_valid[1]}, 6'b0);
            @(posedge clk); #1;
            rst = 1'b0;
            model_last = 1'b1;
            cnt[0] = 0; cnt[1] = 0;
            idle_cycle(1'b1);
            run_round(0, 1, -1, 1'b0, -1, 32'h4000, 32'h4000);
        end

        // Random rounds
        for (int r = 0; r < 20; r++)
            run_round(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, 1'b0, -1, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_read_arbiter.md
AXI4_READ_ARBITER -- requirements
Module: axi4_read_arbiter

Interface
REQ-001 Parameter: CLOCK_INFO, 'b0, std_clock_info_t clock description passed through for timing annotation.
REQ-002 Port: clk  input  1  single clock; all logic rising-edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: axi_ar_in0  axi4_ar_intf.in  intf  read-address channel, master 0.
REQ-005 Port: axi_ar_in1  axi4_ar_intf.in  intf  read-address channel, master 1.
REQ-006 Port: axi_r_out0  axi4_r_intf.out  intf  read-data channel back to master 0.
REQ-007 Port: axi_r_out1  axi4_r_intf.out  intf  read-data channel back to master 1.
REQ-008 Port: axi_ar_out  axi4_ar_intf.out  intf  shared read-address channel to slave.
REQ-009 Port: axi_r_in  axi4_r_intf.in  intf  shared read-data channel from slave.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The block shall share one AXI4 read slave between two masters, with exactly one burst outstanding at a time.
REQ-012 FSM states shall be IDLE, ADDR, DATA.
REQ-013 IDLE: any ar_in valid -> register grant, go to ADDR next cycle; no valid -> stay in IDLE; all readies and out valids 0.
REQ-014 ADDR: axi_ar_out valid and all payload fields (addr, burst, cache, len, lock, prot, qos, size, user, id) shall combinationally mirror the granted master; granted ar_in.ready = axi_ar_out.ready; ungranted ar_in.ready = 0.
REQ-015 ADDR: AR handshake (valid & ready on axi_ar_out) -> DATA next cycle.
REQ-016 DATA: axi_r_in shall route combinationally to the granted r_out (data, last, resp, id unmodified); axi_r_in.ready = granted r_out.ready; ungranted r_out.valid = 0.
REQ-017 DATA: R handshake with last = 1 -> IDLE next cycle; last = 0 handshakes stay in DATA.
REQ-018 Routing shall use the registered grant only, never the R id field.
REQ-019 axi_r_in.ready shall be 0 in IDLE and ADDR; stray slave responses stall and are never forwarded.
REQ-020 Minimum latency: ar_in valid in cycle N -> axi_ar_out valid in cycle N+1; back-to-back bursts have one IDLE cycle between last R beat and next AR.
REQ-021 Granted master dropping valid in ADDR (protocol violation): axi_ar_out.valid follows it; FSM stays in ADDR; grant is not re-arbitrated.
REQ-022 Width rules: addr, id, user widths equal across all AR ports, and data, id widths equal across all R ports, checked with STATIC_ASSERT.

Reset
REQ-023 rst shall force state IDLE, registered grant 0, last_grant 1, busy 0; all ar/r out valids and all readies 0 in the same cycle.
REQ-024 rst asserted mid-burst shall abandon the burst without completing it; remaining slave R beats shall stall per REQ-019.

Configuration
REQ-025 With AXI4_READ_ARBITER_RR_EN defined: round-robin; simultaneous requests grant the master not equal to last_grant; last_grant updates on the final R beat.
REQ-026 Without AXI4_READ_ARBITER_RR_EN: fixed priority; master 0 always wins simultaneous requests; last_grant unused.

Structure
REQ-027 axi4_pkg shall hold the FSM enum axi4_read_arb_state_t (IDLE, ADDR, DATA).
REQ-028 Grant selection (two requesters, last_grant, RR/fixed mode) shall be one sub-module, axi4_grant_select; everything else is inline.

Verification
REQ-029 Single request: m0 AR addr 0x1000 len 3 -> axi_ar_out addr 0x1000 one cycle later; 4 R beats reach r_out0 only; busy drops the cycle after the last beat.
REQ-030 Simultaneous requests under RR_EN: m0 0x100 and m1 0x200 asserted together after reset -> m0 served first, then m1; repeated simultaneous requests alternate m0, m1, m0.
REQ-031 Simultaneous requests without RR_EN: m0 and m1 requesting continuously -> three consecutive grants all go to m0; m1 is never granted.
REQ-032 Backpressure: slave ar ready low 5 cycles, then r_out1 ready toggled every cycle on a len 7 burst -> payload held stable while stalled; 8 beats delivered in order; no beats lost or duplicated.
REQ-033 Stray response: slave drives R valid in IDLE -> axi_r_in.ready stays 0; both r_out valids stay 0.
REQ-034 Reset mid-burst: rst after beat 2 of a len 3 burst -> next cycle IDLE, all valids and readies 0; a fresh m1 request is served normally.
